// File: rtl/mips_hazard_ctrl.sv
// mips_hazard_ctrl: 5-stage MIPS interlock, branch flush and HLT drain control.
// Define FORWARD_EN to compile in the forwarding unit (load-use interlock only).
module mips_hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk1,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic                   id_wr,
  input  logic [4:0]             id_rd,
  input  logic                   id_load,
  input  logic                   id_halt,
  input  logic                   ex_branch_taken,
  output logic                   issue,
  output logic                   stall,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   halted,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count
);
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;
  state_t          r_state, w_state_nx;
  logic [2:0]      r_v, r_ld;
  logic [2:0][4:0] r_rd;
  logic            w_haz_rs, w_haz_rt, w_hazard, w_run, w_unused;
  function automatic logic hit(input logic [4:0] src, input logic v, input logic [4:0] rd);
    return v && src != 5'd0 && src == rd;
  endfunction
  // slot 0 = EX, 1 = MEM, 2 = WB
`ifdef FORWARD_EN
  assign w_haz_rs = hit(id_rs, r_v[0] & r_ld[0], r_rd[0]);
  assign w_haz_rt = hit(id_rt, r_v[0] & r_ld[0], r_rd[0]);
  assign fwd_a = hit(id_rs, r_v[0] & ~r_ld[0], r_rd[0]) ? 2'd1 : hit(id_rs, r_v[1], r_rd[1]) ? 2'd2 : 2'd0;
  assign fwd_b = hit(id_rt, r_v[0] & ~r_ld[0], r_rd[0]) ? 2'd1 : hit(id_rt, r_v[1], r_rd[1]) ? 2'd2 : 2'd0;
`else
  assign w_haz_rs = hit(id_rs, r_v[0], r_rd[0]) | hit(id_rs, r_v[1], r_rd[1]) | hit(id_rs, r_v[2], r_rd[2]);
  assign w_haz_rt = hit(id_rt, r_v[0], r_rd[0]) | hit(id_rt, r_v[1], r_rd[1]) | hit(id_rt, r_v[2], r_rd[2]);
  assign fwd_a = 2'd0;
  assign fwd_b = 2'd0;
`endif
  assign w_unused = ^{r_v, r_rd, r_ld};
  assign w_hazard = id_valid & ((id_use_rs & w_haz_rs) | (id_use_rt & w_haz_rt));
  assign w_run    = r_state == RUN;
  assign issue    = id_valid & ~w_hazard & ~ex_branch_taken & w_run;
  assign stall    = w_hazard & w_run & ~ex_branch_taken;
  assign halted   = r_state == HALTED;
  assign state    = r_state;
  // HLT sitting alone in WB means the pipe is empty after this edge
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = (w_run && issue && id_halt) ? DRAIN :
                 (r_state == DRAIN && !r_v[0] && !r_v[1]) ? HALTED : r_state;
  end
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_v         <= '0;
      r_ld        <= '0;
      r_rd        <= '0;
      stall_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_v     <= {r_v[1:0], issue};
      r_ld    <= {r_ld[1:0], issue & id_load};
      r_rd    <= {r_rd[1:0], id_wr ? id_rd : 5'd0};
      if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// tb_mips_hazard_ctrl: directed and random checks against an age-based issue-history model.
module tb_mips_hazard_ctrl;
  localparam int CW = 4;
  logic clk1 = 0, reset = 0;
  logic id_valid = 0, id_use_rs = 0, id_use_rt = 0, id_wr = 0, id_load = 0, id_halt = 0, ex_branch_taken = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0;
  logic issue, stall, halted;
  logic [1:0] fwd_a, fwd_b, state;
  logic [CW-1:0] stall_count;
  int checks = 0, errors = 0;
  typedef struct {int c; logic [4:0] rd; logic ld;} ent_t;
  ent_t q[$];
  int cyc = 0, halt_c = -1, m_cnt = 0;
  logic l_issue, l_stall;
  logic [1:0] l_fa, l_state;
  logic l_halted;

  always #5 clk1 = ~clk1;

  mips_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk1(clk1), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_rd(id_rd),
    .id_load(id_load), .id_halt(id_halt), .ex_branch_taken(ex_branch_taken),
    .issue(issue), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .state(state), .stall_count(stall_count)
  );

  // An instruction issued in cycle c is in EX at c+1, MEM at c+2, WB at c+3.
  function automatic int m_state();
    return (halt_c < 0) ? 0 : (cyc >= halt_c + 4) ? 2 : 1;
  endfunction

  function automatic bit m_dep(input logic [4:0] src);
    foreach (q[i]) begin
      int a = cyc - q[i].c;
      if (src != 0 && q[i].rd == src && a >= 1 && a <= 3)
`ifdef FORWARD_EN
        if (a == 1 && q[i].ld) return 1;
`else
        return 1;
`endif
    end
    return 0;
  endfunction

  function automatic int m_fwd(input logic [4:0] src);
    int r = 0;
`ifdef FORWARD_EN
    foreach (q[i]) begin
      int a = cyc - q[i].c;
      if (src != 0 && q[i].rd == src) begin
        if (a == 1 && !q[i].ld) return 1;
        if (a == 2) r = 2;
      end
    end
`endif
    return r;
  endfunction

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                      input logic urt, input logic wr, input logic [4:0] rd, input logic ld,
                      input logic hl, input logic br);
    bit haz, e_iss, e_stl;
    int e_fa, e_fb, e_st;
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wr = wr; id_rd = rd; id_load = ld; id_halt = hl; ex_branch_taken = br;
    #1;
    e_st  = m_state();
    haz   = v && ((urs && m_dep(rs)) || (urt && m_dep(rt)));
    e_iss = v && !haz && !br && e_st == 0;
    e_stl = haz && e_st == 0 && !br;
    e_fa  = m_fwd(rs);
    e_fb  = m_fwd(rt);
    checks++;
    if (issue !== e_iss || stall !== e_stl) begin
      errors++;
      $display("FAIL ctl cyc=%0d issue=%b stall=%b expected issue=%b stall=%b", cyc, issue, stall, e_iss, e_stl);
    end
    checks++;
    if (fwd_a !== e_fa[1:0] || fwd_b !== e_fb[1:0]) begin
      errors++;
      $display("FAIL fwd cyc=%0d fwd_a=%0d fwd_b=%0d expected %0d %0d", cyc, fwd_a, fwd_b, e_fa, e_fb);
    end
    checks++;
    if (state !== e_st[1:0] || halted !== (e_st == 2) || stall_count !== m_cnt[CW-1:0]) begin
      errors++;
      $display("FAIL status cyc=%0d state=%0d halted=%b count=%0d expected %0d %b %0d",
               cyc, state, halted, stall_count, e_st, e_st == 2, m_cnt);
    end
    l_issue = issue; l_stall = stall; l_fa = fwd_a; l_state = state; l_halted = halted;
    if (e_iss) begin
      q.push_back('{c: cyc, rd: (wr ? rd : 5'd0), ld: ld});
      if (hl) halt_c = cyc;
    end
    if (e_stl && m_cnt < (1 << CW) - 1) m_cnt++;
    @(posedge clk1);
    cyc++;
    while (q.size() > 0 && cyc - q[0].c > 3) void'(q.pop_front());
    @(negedge clk1);
  endtask

  task automatic ins(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                     input logic ld, input logic br);
    step(1, rs, rt, 1, 1, 1, rd, ld, 0, br);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic hlt();
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic apply_reset();
    reset = 1;
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_wr = 0; id_load = 0; id_halt = 0; ex_branch_taken = 0;
    #1;
    checks++;
    if (issue !== 0 || stall !== 0 || fwd_a !== 0 || fwd_b !== 0 || state !== 0 || halted !== 0 || stall_count !== 0) begin
      errors++;
      $display("FAIL reset issue=%b stall=%b fwd=%0d/%0d state=%0d halted=%b count=%0d expected all zero",
               issue, stall, fwd_a, fwd_b, state, halted, stall_count);
    end
    q.delete(); halt_c = -1; m_cnt = 0;
    @(posedge clk1);
    @(negedge clk1);
    reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    nop();
  endtask

  // returns stall cycles seen before the consumer issued, and fwd_a on the issue cycle
  task automatic run_consumer(output int n, output logic [1:0] fa);
    n = 0; fa = 0;
    for (int k = 0; k < 8; k++) begin
      ins(4, 1, 2, 0, 0);
      if (l_issue) begin fa = l_fa; break; end
      n++;
    end
    checks++;
    if (!l_issue) begin errors++; $display("FAIL consumer_issue never issued within 8 cycles"); end
  endtask

  task automatic test_raw_alu();
    int n, en, ef; logic [1:0] fa;
`ifdef FORWARD_EN
    en = 0; ef = 1;
`else
    en = 3; ef = 0;
`endif
    apply_reset();
    ins(1, 0, 0, 0, 0);
    run_consumer(n, fa);
    checks++;
    if (n != en || fa !== ef[1:0] || stall_count !== en[CW-1:0]) begin
      errors++;
      $display("FAIL raw_alu stalls=%0d fwd_a=%0d count=%0d expected %0d %0d %0d", n, fa, stall_count, en, ef, en);
    end
  endtask

  task automatic test_load_use();
    int n, en, ef; logic [1:0] fa;
`ifdef FORWARD_EN
    en = 1; ef = 2;
`else
    en = 3; ef = 0;
`endif
    apply_reset();
    ins(1, 0, 0, 1, 0);
    run_consumer(n, fa);
    checks++;
    if (n != en || fa !== ef[1:0]) begin
      errors++;
      $display("FAIL load_use stalls=%0d fwd_a=%0d expected %0d %0d", n, fa, en, ef);
    end
  endtask

  task automatic test_wb_gap_r0();
    int n, en; logic [1:0] fa;
`ifdef FORWARD_EN
    en = 0;
`else
    en = 1;
`endif
    apply_reset();
    ins(1, 0, 0, 0, 0);
    ins(7, 0, 0, 0, 0);
    ins(7, 0, 0, 0, 0);
    run_consumer(n, fa);
    checks++;
    if (n != en || fa !== 2'd0) begin
      errors++;
      $display("FAIL wb_gap stalls=%0d fwd_a=%0d expected %0d 0", n, fa, en);
    end
    apply_reset();
    ins(0, 0, 0, 1, 0);
    ins(5, 0, 0, 0, 0);
    checks++;
    if (l_stall !== 0 || l_issue !== 1) begin
      errors++;
      $display("FAIL r0 stall=%b issue=%b expected 0 1", l_stall, l_issue);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    ins(1, 0, 0, 0, 0);
    ins(4, 1, 2, 0, 1);
    checks++;
    if (l_issue !== 0 || l_stall !== 0) begin
      errors++;
      $display("FAIL branch issue=%b stall=%b expected 0 0", l_issue, l_stall);
    end
    ins(6, 4, 4, 0, 0);
    checks++;
    if (l_issue !== 1) begin
      errors++;
      $display("FAIL branch_drop issue=%b expected 1", l_issue);
    end
  endtask

  task automatic test_halt();
    logic [1:0] exp_st [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
    apply_reset();
    hlt();
    for (int k = 0; k < 5; k++) begin
      nop();
      checks++;
      if (l_state !== exp_st[k < 4 ? k : 3] || l_halted !== (k >= 3)) begin
        errors++;
        $display("FAIL halt_seq k=%0d state=%0d halted=%b expected %0d %b", k, l_state, l_halted, exp_st[k < 4 ? k : 3], k >= 3);
      end
    end
    apply_reset();
    hlt();
    nop();
    apply_reset();
    ins(1, 0, 0, 0, 0);
    ins(4, 1, 2, 0, 0);
    apply_reset();
    ins(4, 1, 2, 0, 0);
    checks++;
    if (l_issue !== 1 || l_stall !== 0) begin
      errors++;
      $display("FAIL reset_mid_stall issue=%b stall=%b expected 1 0", l_issue, l_stall);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      if (halt_c >= 0 && cyc >= halt_c + 6) apply_reset();
      step($urandom_range(3) != 0, 5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom),
           1'($urandom), 1'($urandom), 5'($urandom_range(3)), $urandom_range(3) == 0,
           $urandom_range(99) == 0, $urandom_range(7) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_raw_alu();
    test_load_use();
    test_wb_gap_r0();
    test_branch();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_hazard_ctrl.md
MIPS_HAZARD_CTRL -- requirements
Module: mips_hazard_ctrl

Interface
REQ-001 Parameter: STALL_CNT_W, default 16, width of the stall event counter.
REQ-002 Port: clk1  input  1  single pipeline clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: id_valid  input  1  a decoded instruction is present in ID.
REQ-005 Port: id_rs, id_rt  input  5 each  source register numbers of the ID instruction.
REQ-006 Port: id_use_rs, id_use_rt  input  1 each  ID instruction reads rs or rt.
REQ-007 Port: id_wr, id_rd  input  1 / 5  ID instruction writes register id_rd.
REQ-008 Port: id_load, id_halt  input  1 each  ID instruction is a LW or an HLT.
REQ-009 Port: ex_branch_taken  input  1  branch resolved taken in EX; flush ID.
REQ-010 Port: issue  output  1  ID instruction advances into EX this cycle.
REQ-011 Port: stall  output  1  hold PC and IF/ID; insert a bubble into EX.
REQ-012 Port: fwd_a, fwd_b  output  2 each  operand source: 0 = register file, 1 = EX/MEM, 2 = MEM/WB.
REQ-013 Port: halted  output  1  pipeline drained after HLT; sticky.
REQ-014 Port: state  output  2  FSM state: 0 = RUN, 1 = DRAIN, 2 = HALTED.
REQ-015 Port: stall_count  output  STALL_CNT_W  number of cycles with stall = 1, saturating.

Function
REQ-016 Three in-flight slots (EX, MEM, WB) SHALL each hold {valid, rd, load}; they shift EX->MEM->WB every cycle, and the WB entry retires.
REQ-017 hazard SHALL be 1 when id_valid is 1 and a used source (rs when id_use_rs, rt when id_use_rt) equals the rd of a valid matching slot, excluding register 0.
REQ-018 Matching slots without FORWARD_EN: EX, MEM, WB. Matching slots with FORWARD_EN: only the EX slot, and only when its load bit is 1.
REQ-019 stall SHALL equal hazard AND state==RUN AND NOT ex_branch_taken.
REQ-020 issue SHALL equal id_valid AND NOT hazard AND NOT ex_branch_taken AND state==RUN; both outputs are combinational from inputs and slots.
REQ-021 The EX slot SHALL load {1, id_rd when id_wr else 0, id_load} when issue is 1, and a bubble (valid = 0) otherwise.
REQ-022 ex_branch_taken SHALL take priority over hazard: issue = 0, stall = 0, the ID instruction is discarded, and the slots still shift.
REQ-023 FSM: RUN -> DRAIN on a cycle with issue = 1 and id_halt = 1; DRAIN -> HALTED when EX, MEM and WB are all invalid; HALTED is terminal until reset.
REQ-024 In DRAIN and HALTED, issue = 0 and stall = 0; halted = 1 only in HALTED.
REQ-025 stall_count SHALL increment on every cycle with stall = 1 and hold at all-ones (no wrap-around).
REQ-026 fwd_a and fwd_b SHALL be 0 without FORWARD_EN. With it, fwd_x SHALL be 1 if the source matches a valid non-load EX slot, else 2 if it matches a valid MEM slot, else 0; register 0 always gives 0, and EX takes priority when both match.

Reset
REQ-027 Reset asserted SHALL immediately clear all slots, set state = RUN, halted = 0 and stall_count = 0; issue, stall, fwd_a and fwd_b then evaluate to 0 with no slot valid and id_valid = 0.
REQ-028 Reset mid-DRAIN or mid-stall SHALL abandon in-flight tracking entirely, with no residual stall after release.

Configuration
REQ-029 Macro FORWARD_EN: when defined, the forwarding unit is compiled in (REQ-018 load-use only, REQ-026 fwd select). When undefined, it is compiled out: full interlock on EX/MEM/WB, and fwd_a/fwd_b are tied to 0.

Verification
REQ-030 ADDI R1 issued, ADD R4,R1,R2 next cycle, no FORWARD_EN -> stall high 3 cycles, ADD issues on the 4th cycle, stall_count = 3.
REQ-031 Same sequence with FORWARD_EN -> no stall, fwd_a = 1 on the ADD issue cycle, stall_count = 0.
REQ-032 LW R1 then ADD R4,R1,R2 with FORWARD_EN -> exactly 1 stall cycle, then issue with fwd_a = 2.
REQ-033 ADDI R1, two OR R7 dummy instructions, ADD R4,R1,R2, no FORWARD_EN -> 1 stall cycle; source R0 with a pending write to R0 -> never stall.
REQ-034 ex_branch_taken during a hazard cycle -> issue = 0, stall = 0, the ID instruction is dropped; HLT issued -> state = 1 for 3 cycles, then state = 2 and halted = 1; reset asserted in DRAIN -> state = 0 and halted = 0 immediately.
